// File: rtl/sector_read_sequencer_if.sv
// Bus between command_fsm / read datapath and the sector read sequencer.
// The master side issues the command and drives the datapath inputs;
// the slave side is the sequencer itself.
interface sector_read_sequencer_if;
  // command side
  logic       start;
  logic       abort;
  logic [7:0] target_c;
  logic [7:0] target_h;
  logic [7:0] target_r;
  logic [7:0] target_n;
  // datapath side
  logic       index_pulse;
  logic       sync_acquired;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       crc_valid;
  logic       fifo_full;
  // sequencer outputs
  logic       read_enable;
  logic       crc_init;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       done;
  logic       missing_am;
  logic       no_data;
  logic       crc_error_id;
  logic       crc_error_data;
  logic       overrun;
  logic       deleted_mark;

  modport master (
    output start, abort, target_c, target_h, target_r, target_n,
    output index_pulse, sync_acquired, byte_in, byte_valid, crc_valid, fifo_full,
    input  read_enable, crc_init, data_out, data_valid, busy, done,
    input  missing_am, no_data, crc_error_id, crc_error_data, overrun, deleted_mark
  );

  modport slave (
    input  start, abort, target_c, target_h, target_r, target_n,
    input  index_pulse, sync_acquired, byte_in, byte_valid, crc_valid, fifo_full,
    output read_enable, crc_init, data_out, data_valid, busy, done,
    output missing_am, no_data, crc_error_id, crc_error_data, overrun, deleted_mark
  );
endinterface

// File: rtl/sector_read_sequencer.sv
// Single-sector read sequencer: hunts for the ID field matching C/H/R/N,
// locates the data field, streams data bytes to the FIFO and reports
// 82077-style status flags.
//
// state         | meaning
// --------------+-------------------------------------------------------
// IDLE          | waiting for start; flags hold the last result
// WAIT_ID_AM    | hunting for an ID address mark (0xFE)
// READ_ID       | collecting C, H, R, N, CRC1, CRC2
// CHECK_ID      | sampling crc_valid and the target comparison
// WAIT_DATA_AM  | hunting for the data mark (0xFB / 0xF8) inside the window
// READ_DATA     | forwarding data bytes, then swallowing the two CRC bytes
// CHECK_DATA    | sampling crc_valid for the data field
// DONE          | one-cycle completion pulse
module sector_read_sequencer #(
  parameter int MAX_REVS       = 2,
  parameter int DATA_AM_WINDOW = 43
) (
  input logic                    clk_i,
  input logic                    reset_i,
  sector_read_sequencer_if.slave bus
);

  localparam int REV_W = $clog2(MAX_REVS + 1);
  localparam int WIN_W = $clog2(DATA_AM_WINDOW + 1);

  localparam logic [7:0] MARK_ID   = 8'hFE;
  localparam logic [7:0] MARK_DATA = 8'hFB;
  localparam logic [7:0] MARK_DEL  = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ID_AM,
    ST_READ_ID,
    ST_CHECK_ID,
    ST_WAIT_DATA_AM,
    ST_READ_DATA,
    ST_CHECK_DATA,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               sync_q, sync_d;
  logic               idx_q, idx_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic               mark_pend_q, mark_pend_d;
  logic [2:0]         id_cnt_q, id_cnt_d;
  logic               id_match_q, id_match_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [14:0]        byte_cnt_q, byte_cnt_d;
  logic               crc_cnt_q, crc_cnt_d;
  logic               id_seen_q, id_seen_d;
  logic               id_crc_seen_q, id_crc_seen_d;
  logic               missing_am_q, missing_am_d;
  logic               no_data_q, no_data_d;
  logic               crc_error_id_q, crc_error_id_d;
  logic               crc_error_data_q, crc_error_data_d;
  logic               overrun_q, overrun_d;
  logic               deleted_mark_q, deleted_mark_d;

  logic               sync_rise;
  logic               idx_rise;
  logic               mark_strobe;
  logic               rev_reached;
  logic               timeout_hit;
  logic               data_valid_c;
  logic [7:0]         id_target;

  assign sync_rise   = bus.sync_acquired & ~sync_q;
  assign idx_rise    = bus.index_pulse & ~idx_q;
  // A byte arriving in the same cycle as the sync rise precedes the mark.
  assign mark_strobe = bus.byte_valid & mark_pend_q & ~sync_rise;
  assign rev_reached = (rev_cnt_q == REV_W'(MAX_REVS));

  // Target byte the current ID byte is compared against.
  always_comb begin
    id_target = bus.target_n;
    case (id_cnt_q)
      3'd0:    id_target = bus.target_c;
      3'd1:    id_target = bus.target_h;
      3'd2:    id_target = bus.target_r;
      default: id_target = bus.target_n;
    endcase
  end

  // State and datapath register update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      sync_q           <= 1'b0;
      idx_q            <= 1'b0;
      rev_cnt_q        <= '0;
      mark_pend_q      <= 1'b0;
      id_cnt_q         <= '0;
      id_match_q       <= 1'b0;
      win_cnt_q        <= '0;
      byte_cnt_q       <= '0;
      crc_cnt_q        <= 1'b0;
      id_seen_q        <= 1'b0;
      id_crc_seen_q    <= 1'b0;
      missing_am_q     <= 1'b0;
      no_data_q        <= 1'b0;
      crc_error_id_q   <= 1'b0;
      crc_error_data_q <= 1'b0;
      overrun_q        <= 1'b0;
      deleted_mark_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      sync_q           <= sync_d;
      idx_q            <= idx_d;
      rev_cnt_q        <= rev_cnt_d;
      mark_pend_q      <= mark_pend_d;
      id_cnt_q         <= id_cnt_d;
      id_match_q       <= id_match_d;
      win_cnt_q        <= win_cnt_d;
      byte_cnt_q       <= byte_cnt_d;
      crc_cnt_q        <= crc_cnt_d;
      id_seen_q        <= id_seen_d;
      id_crc_seen_q    <= id_crc_seen_d;
      missing_am_q     <= missing_am_d;
      no_data_q        <= no_data_d;
      crc_error_id_q   <= crc_error_id_d;
      crc_error_data_q <= crc_error_data_d;
      overrun_q        <= overrun_d;
      deleted_mark_q   <= deleted_mark_d;
    end
  end

  // Next-state, counters, flags and the per-byte FIFO strobe.
  always_comb begin
    state_d          = state_q;
    sync_d           = bus.sync_acquired;
    idx_d            = bus.index_pulse;
    rev_cnt_d        = rev_cnt_q;
    mark_pend_d      = mark_pend_q;
    id_cnt_d         = id_cnt_q;
    id_match_d       = id_match_q;
    win_cnt_d        = win_cnt_q;
    byte_cnt_d       = byte_cnt_q;
    crc_cnt_d        = crc_cnt_q;
    id_seen_d        = id_seen_q;
    id_crc_seen_d    = id_crc_seen_q;
    missing_am_d     = missing_am_q;
    no_data_d        = no_data_q;
    crc_error_id_d   = crc_error_id_q;
    crc_error_data_d = crc_error_data_q;
    overrun_d        = overrun_q;
    deleted_mark_d   = deleted_mark_q;
    timeout_hit      = 1'b0;
    data_valid_c     = 1'b0;

    // Every sync rise arms the mark detector; the next byte is the mark.
    if (sync_rise) begin
      mark_pend_d = 1'b1;
    end else if (mark_strobe) begin
      mark_pend_d = 1'b0;
    end

    // Revolutions are only counted while hunting for the ID.
    if (((state_q == ST_WAIT_ID_AM) || (state_q == ST_READ_ID)) && idx_rise && !rev_reached) begin
      rev_cnt_d = rev_cnt_q + REV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d          = ST_WAIT_ID_AM;
          rev_cnt_d        = '0;
          mark_pend_d      = 1'b0;
          id_seen_d        = 1'b0;
          id_crc_seen_d    = 1'b0;
          missing_am_d     = 1'b0;
          no_data_d        = 1'b0;
          crc_error_id_d   = 1'b0;
          crc_error_data_d = 1'b0;
          overrun_d        = 1'b0;
          deleted_mark_d   = 1'b0;
        end
      end

      ST_WAIT_ID_AM: begin
        if (mark_strobe && (bus.byte_in == MARK_ID)) begin
          state_d    = ST_READ_ID;
          id_seen_d  = 1'b1;
          id_cnt_d   = '0;
          id_match_d = 1'b1;
        end else if (rev_reached) begin
          timeout_hit = 1'b1;
        end
      end

      // An ID already under way is allowed to finish; the revolution
      // limit is then applied in CHECK_ID if it did not match.
      ST_READ_ID: begin
        if (sync_rise) begin
          state_d = ST_WAIT_ID_AM;
        end else if (bus.byte_valid) begin
          if (id_cnt_q < 3'd4) begin
            id_match_d = id_match_q & (bus.byte_in == id_target);
          end
          if (id_cnt_q == 3'd5) begin
            state_d = ST_CHECK_ID;
          end else begin
            id_cnt_d = id_cnt_q + 3'd1;
          end
        end
      end

      ST_CHECK_ID: begin
        if (!bus.crc_valid) begin
          id_crc_seen_d = 1'b1;
          state_d       = ST_WAIT_ID_AM;
          timeout_hit   = rev_reached;
        end else if (id_match_q) begin
          state_d   = ST_WAIT_DATA_AM;
          win_cnt_d = '0;
        end else begin
          state_d     = ST_WAIT_ID_AM;
          timeout_hit = rev_reached;
        end
      end

      ST_WAIT_DATA_AM: begin
        if (mark_strobe) begin
          if ((bus.byte_in == MARK_DATA) || (bus.byte_in == MARK_DEL)) begin
            state_d        = ST_READ_DATA;
            byte_cnt_d     = 15'd128 << bus.target_n[2:0];
            crc_cnt_d      = 1'b0;
            deleted_mark_d = (bus.byte_in == MARK_DEL);
          end else begin
            missing_am_d = 1'b1;
            state_d      = ST_DONE;
          end
        end else if (bus.byte_valid) begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if ((win_cnt_q == WIN_W'(DATA_AM_WINDOW - 1)) && !mark_pend_q && !sync_rise) begin
            missing_am_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end

      ST_READ_DATA: begin
        if (bus.byte_valid) begin
          if (byte_cnt_q != 15'd0) begin
            if (bus.fifo_full) begin
              overrun_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              data_valid_c = 1'b1;
              byte_cnt_d   = byte_cnt_q - 15'd1;
            end
          end else if (crc_cnt_q) begin
            state_d = ST_CHECK_DATA;
          end else begin
            crc_cnt_d = 1'b1;
          end
        end
      end

      ST_CHECK_DATA: begin
        crc_error_data_d = ~bus.crc_valid;
        state_d          = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Search exhausted: report the most specific thing that was seen.
    if (timeout_hit) begin
      state_d = ST_DONE;
      if (id_crc_seen_d) begin
        crc_error_id_d = 1'b1;
      end else if (id_seen_d) begin
        no_data_d = 1'b1;
      end else begin
        missing_am_d = 1'b1;
      end
    end

    if (bus.abort) begin
      state_d          = ST_IDLE;
      rev_cnt_d        = '0;
      mark_pend_d      = 1'b0;
      id_seen_d        = 1'b0;
      id_crc_seen_d    = 1'b0;
      missing_am_d     = 1'b0;
      no_data_d        = 1'b0;
      crc_error_id_d   = 1'b0;
      crc_error_data_d = 1'b0;
      overrun_d        = 1'b0;
      deleted_mark_d   = 1'b0;
      data_valid_c     = 1'b0;
    end
  end

  assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.read_enable    = bus.busy;
  assign bus.done           = (state_q == ST_DONE);
  assign bus.crc_init       = sync_rise & bus.busy;
  assign bus.data_valid     = data_valid_c;
  assign bus.data_out       = data_valid_c ? bus.byte_in : 8'h00;
  assign bus.missing_am     = missing_am_q;
  assign bus.no_data        = no_data_q;
  assign bus.crc_error_id   = crc_error_id_q;
  assign bus.crc_error_data = crc_error_data_q;
  assign bus.overrun        = overrun_q;
  assign bus.deleted_mark   = deleted_mark_q;

endmodule

// File: tb/tb_sector_read_sequencer.sv
// Directed bench for sector_read_sequencer: clean reads, ID hunt failures,
// data-mark window, deleted mark, overrun, abort and asynchronous reset.
module tb_sector_read_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sector_read_sequencer_if bus ();

  sector_read_sequencer #(.MAX_REVS(2), .DATA_AM_WINDOW(43)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pat      = 8'h11;

  // Capture FIFO writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) rx_q.push_back(bus.data_out);
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    cyc(1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic sync_mark(input logic [7:0] m);
    bus.sync_acquired = 1'b1;
    #1;
    check("crc_init_on_sync_rise", bus.crc_init, 1'b1);
    cyc(1);
    send_byte(m);
    bus.sync_acquired = 1'b0;
    cyc(1);
  endtask

  task automatic send_id(input logic [7:0] c, input logic [7:0] h, input logic [7:0] r,
                         input logic [7:0] n, input logic ok);
    sync_mark(8'hFE);
    send_byte(c); cyc(1);
    send_byte(h); cyc(1);
    send_byte(r); cyc(1);
    send_byte(n); cyc(1);
    bus.crc_valid = ok;
    send_byte(8'hA5); cyc(1);
    send_byte(8'h5A); cyc(1);
    bus.crc_valid = 1'b0;
  endtask

  task automatic data_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      pat = pat * 8'd5 + 8'd3;
      exp_q.push_back(pat);
      send_byte(pat);
      cyc(1);
    end
  endtask

  task automatic send_data(input logic [7:0] mark, input int n, input logic ok);
    sync_mark(mark);
    data_bytes(n);
    bus.crc_valid = ok;
    send_byte(8'h3C); cyc(1);
    send_byte(8'hC3);
    check("no_done_in_check_data", bus.done, 1'b0);
    cyc(1);
    check("done_two_cycles_after_crc", bus.done, 1'b1);
    bus.crc_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int mism = 0;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    check({tag, "_data"}, mism, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_flags(input string tag, input logic [5:0] expv);
    check(tag, {bus.missing_am, bus.no_data, bus.crc_error_id,
                bus.crc_error_data, bus.overrun, bus.deleted_mark}, expv);
  endtask

  task automatic set_targets(input logic [7:0] c, input logic [7:0] h,
                             input logic [7:0] r, input logic [7:0] n);
    bus.target_c = c; bus.target_h = h; bus.target_r = r; bus.target_n = n;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic index_edge();
    bus.index_pulse = 1'b1;
    cyc(1);
    bus.index_pulse = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    check(tag, found, 1'b1);
  endtask

  int dc_before;

  // Flag order in check_flags: missing_am, no_data, crc_error_id,
  // crc_error_data, overrun, deleted_mark.
  initial begin
    bus.start = 0; bus.abort = 0; bus.index_pulse = 0; bus.sync_acquired = 0;
    bus.byte_in = 0; bus.byte_valid = 0; bus.crc_valid = 0; bus.fifo_full = 0;
    set_targets(8'h02, 8'h00, 8'h05, 8'h02);
    cyc(3);
    reset = 1'b0;
    cyc(1);

    check("reset_busy", bus.busy, 1'b0);
    check("reset_read_enable", bus.read_enable, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_data_valid", bus.data_valid, 1'b0);
    check("reset_crc_init", bus.crc_init, 1'b0);
    check("reset_data_out", bus.data_out, 8'h00);
    check_flags("reset_flags", 6'b000000);

    // Clean 512-byte sector
    do_start();
    check("start_busy", bus.busy, 1'b1);
    check("start_read_enable", bus.read_enable, 1'b1);
    send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b1);
    send_data(8'hFB, 512, 1'b1);
    check("clean_busy_in_done", bus.busy, 1'b0);
    check_flags("clean_flags", 6'b000000);
    check_stream("clean_stream");
    cyc(1);
    check("clean_back_to_idle", bus.done, 1'b0);

    // Wrong sector (R=04 with its data field) then the right one, n=1
    set_targets(8'h02, 8'h00, 8'h05, 8'h01);
    do_start();
    send_id(8'h02, 8'h00, 8'h04, 8'h01, 1'b1);
    sync_mark(8'hFB);
    for (int i = 0; i < 10; i++) begin send_byte(8'hE5); cyc(1); end
    check("wrong_sector_no_data", rx_q.size(), 0);
    send_id(8'h02, 8'h00, 8'h05, 8'h01, 1'b1);
    send_data(8'hFB, 256, 1'b1);
    check_flags("wrong_sector_flags", 6'b000000);
    check_stream("wrong_sector_stream");
    cyc(1);

    // No marks, two index edges
    do_start();
    cyc(2); index_edge(); cyc(2);
    check("one_rev_still_busy", bus.busy, 1'b1);
    index_edge();
    wait_done("no_marks_done", 10);
    check_flags("no_marks_flags", 6'b100000);
    check("no_marks_no_data_strobes", rx_q.size(), 0);
    cyc(1);

    // Matching ID with bad CRC every pass
    set_targets(8'h02, 8'h00, 8'h05, 8'h02);
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b0);
    index_edge(); cyc(2);
    send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b0);
    index_edge();
    wait_done("bad_id_crc_done", 10);
    check_flags("bad_id_crc_flags", 6'b001000);
    cyc(1);

    // Good IDs that never match
    do_start();
    send_id(8'h02, 8'h00, 8'h09, 8'h02, 1'b1);
    index_edge(); cyc(2);
    send_id(8'h02, 8'h00, 8'h09, 8'h02, 1'b1);
    index_edge();
    wait_done("no_match_done", 10);
    check_flags("no_match_flags", 6'b010000);
    cyc(1);

    // Data AM window expires on the 43rd byte; a start meanwhile is ignored
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h02, 1'b1);
    for (int i = 0; i < 20; i++) begin send_byte(8'h4E); cyc(1); end
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    for (int i = 0; i < 22; i++) begin send_byte(8'h4E); cyc(1); end
    check("window_42_no_done", bus.done, 1'b0);
    check("window_42_busy", bus.busy, 1'b1);
    send_byte(8'h4E);
    check("window_43_done", bus.done, 1'b1);
    check_flags("window_flags", 6'b100000);
    check("window_no_data_strobes", rx_q.size(), 0);
    cyc(1);

    // Deleted mark, n=0
    set_targets(8'h02, 8'h00, 8'h05, 8'h00);
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h00, 1'b1);
    send_data(8'hF8, 128, 1'b1);
    check_flags("deleted_flags", 6'b000001);
    check_stream("deleted_stream");
    cyc(1);

    // Bad data CRC
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h00, 1'b1);
    send_data(8'hFB, 128, 1'b0);
    check_flags("bad_data_crc_flags", 6'b000100);
    check_stream("bad_data_crc_stream");
    cyc(1);

    // FIFO full at data byte 10
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h00, 1'b1);
    sync_mark(8'hFB);
    data_bytes(9);
    bus.fifo_full = 1'b1;
    send_byte(8'h77);
    bus.fifo_full = 1'b0;
    check("overrun_done_next_cycle", bus.done, 1'b1);
    check_flags("overrun_flags", 6'b000010);
    check_stream("overrun_stream");
    cyc(1);

    // Abort mid-READ_DATA (deleted mark set beforehand, abort clears it)
    dc_before = done_cnt;
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h00, 1'b1);
    sync_mark(8'hF8);
    data_bytes(20);
    check("pre_abort_deleted", bus.deleted_mark, 1'b1);
    bus.abort = 1'b1; cyc(1); bus.abort = 1'b0;
    check("abort_read_enable", bus.read_enable, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check_flags("abort_flags", 6'b000000);
    cyc(5);
    check("abort_no_done", done_cnt, dc_before);
    check_stream("abort_stream");

    // Asynchronous reset mid-transfer
    do_start();
    send_id(8'h02, 8'h00, 8'h05, 8'h00, 1'b1);
    sync_mark(8'hFB);
    data_bytes(5);
    bus.byte_in = 8'h99; bus.byte_valid = 1'b1;
    #2;
    check("pre_reset_data_valid", bus.data_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_data_valid", bus.data_valid, 1'b0);
    check("async_reset_busy", bus.busy, 1'b0);
    check("async_reset_read_enable", bus.read_enable, 1'b0);
    check("async_reset_data_out", bus.data_out, 8'h00);
    bus.byte_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("post_reset_idle", bus.busy, 1'b0);
    check_stream("reset_stream");
    check("total_done_pulses", done_cnt, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sector_read_sequencer.md
Name: sector_read_sequencer

Overview:
- Controller that sequences the read datapath (digital PLL, AM detector, CRC engine) for a single sector read. Sits between command_fsm and the datapath.
- Enables the data separator and hunts for an ID field matching C/H/R/N. It then locates the data field, streams data bytes to the FIFO and reports 82077-style error flags.
- Owns read_enable and crc_init, and replaces the direct command_fsm-to-datapath wiring.

Parameters:
MAX_REVS, 2, index rising edges after start before the search ends.
DATA_AM_WINDOW, 43, byte_valid strobes allowed after the ID CRC before a missing data AM is declared.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; ignored while busy
abort  in  1  return to IDLE immediately
target_c, target_h, target_r, target_n  in  8 each  sector ID to match; target_n also sets the size (128 << n[2:0])
index_pulse  in  1  synchronised index level; edges detected internally
sync_acquired  in  1  AM detector: three A1 sync marks seen (level)
byte_in  in  8  assembled byte from the AM detector
byte_valid  in  1  one-cycle strobe for byte_in
crc_valid  in  1  CRC residual is zero
fifo_full  in  1  FIFO back-pressure
read_enable  out  1  enables the DPLL and AM detector
crc_init  out  1  one-cycle CRC preset (the preset includes A1x3)
data_out  out  8  sector data byte
data_valid  out  1  one-cycle FIFO write strobe
busy  out  1  high from start until done or abort
done  out  1  one-cycle completion pulse
missing_am, no_data, crc_error_id, crc_error_data, overrun, deleted_mark  out  1 each  status flags, valid from done until the next start

Behaviour:

Reset and start/abort
- Reset: all outputs 0, state IDLE, counters 0.
- start in IDLE: clear all flags and the index counter, set busy and read_enable, go to WAIT_ID_AM.
- A start while busy is ignored.
- abort in any state: IDLE next cycle, read_enable=0, busy=0, no done pulse, flags cleared.

Common rules
- crc_init pulses one cycle on every sync_acquired rising edge.
- Any sync_acquired rise restarts the ID/data AM hunt as defined per state.
- The index counter increments on index_pulse rising edges in WAIT_ID_AM and READ_ID.

WAIT_ID_AM
- The first byte_valid after a sync_acquired rise is the mark byte.
- Mark 0xFE: go to READ_ID and set the id_seen flag.
- Any other mark: stay in WAIT_ID_AM.

READ_ID
- Captures C, H, R, N and CRC1, CRC2 (6 strobes).
- CHECK_ID (1 cycle after the 6th strobe) samples crc_valid:
  - CRC bad: set the internal id_crc_seen flag, go to WAIT_ID_AM.
  - CRC good and all four bytes equal the targets: go to WAIT_DATA_AM with the window counter at 0.
  - CRC good but mismatch: go to WAIT_ID_AM.

Search timeout
- When the index counter reaches MAX_REVS while in WAIT_ID_AM or READ_ID, go to DONE.
- Flag set on timeout:
  - id_crc_seen set: crc_error_id=1.
  - else id_seen set: no_data=1.
  - else: missing_am=1.

WAIT_DATA_AM
- Each byte_valid increments the window counter.
- Counter reaches DATA_AM_WINDOW with no sync_acquired rise: set missing_am, go to DONE.
- After a sync rise, the next mark byte decides:
  - 0xFB: go to READ_DATA.
  - 0xF8: set deleted_mark, go to READ_DATA.
  - Anything else: set missing_am, go to DONE.

READ_DATA
- Byte counter is 15 bits, loaded with 128 << target_n[2:0], which gives up to 16384 bytes.
- Each data byte_valid drives data_out=byte_in with data_valid=1 in the same cycle, then decrements the counter.
- A data byte arriving while fifo_full=1 is not written: set overrun, go to DONE.
- After the last data byte, two CRC bytes are consumed and not forwarded.
- CHECK_DATA, 1 cycle after the 2nd CRC byte: crc_valid=0 sets crc_error_data.

DONE
- One cycle: done=1, busy=0, read_enable=0, then IDLE.
- Latency: done follows the final CRC byte strobe by 2 cycles (CHECK_DATA, then DONE).

Simultaneous events
- abort beats everything.
- byte_valid and an index edge in the same cycle: the byte is processed first; timeout is checked after a non-matching ID.
- overrun beats a data CRC check.

Test Plan:
- Clean sector: ID {02,00,05,02} matching the targets with good CRC, then FB, 512 bytes and good CRC -> 512 data_valid strobes in order, done 2 cycles after the last CRC byte, all flags 0.
- Wrong sector first: ID R=04, then ID R=05 -> data from the R=05 sector only, no flags.
- No marks at all, 2 index edges -> done with missing_am=1, zero data_valid strobes.
- Matching ID with a bad CRC on every pass, MAX_REVS reached -> crc_error_id=1, no_data=0.
- Matching ID, data AM never arrives within 43 bytes -> missing_am=1; deleted mark F8 with n=0 -> 128 bytes transferred and deleted_mark=1.
- fifo_full asserted at data byte 10 -> 9 bytes written, overrun=1, done next cycle.
- abort mid-READ_DATA -> read_enable=0 next cycle, no done.
- Reset mid-transfer -> all outputs 0 asynchronously.
